// File: rtl/ce_gen_pkg.sv
// ce_gen_pkg: shared constants and types for the multi-channel clock-enable generator.
package ce_gen_pkg;
  localparam int NUM_CH_MAX = 8;
  localparam int CH_W = $clog2(NUM_CH_MAX);
  localparam int SPEED_W_DEF = 2;
  localparam logic [23:0] INC_CPU_3M58  = 24'h100000;
  localparam logic [23:0] INC_PSG_1M79  = 24'h080000;
  localparam logic [23:0] INC_TAPE_3K33 = 24'h0003D0;
  typedef logic [SPEED_W_DEF-1:0] speed_t;
endpackage

// File: rtl/ce_gen_chan.sv
// ce_gen_chan: one DDA phase accumulator with increment register, turbo shift and pulse-aligned speed latch.
module ce_gen_chan
  import ce_gen_pkg::*;
#(
  parameter int ACC_W   = 24,
  parameter int SPEED_W = SPEED_W_DEF
) (
  input  logic               clk_sys,
  input  logic               reset_n,
  input  logic               wr,
  input  logic [ACC_W-1:0]   inc_in,
  input  logic [SPEED_W-1:0] speed_in,
  input  logic               fast,
  input  logic               clr,
  output logic               ce,
  output logic [SPEED_W-1:0] speed_act
);
  localparam int STEP_W = ACC_W + 2**SPEED_W - 1;
  logic [ACC_W-1:0]   acc_q, acc_d, inc_q, inc_d;
  logic [SPEED_W-1:0] spd_q, spd_d;
  logic               ce_q, ce_d;
  logic [STEP_W-1:0]  step;
  logic [ACC_W:0]     sum;
  logic               sat;
  always_comb begin
    step  = STEP_W'(inc_q) << spd_q;
    sat   = |step[STEP_W-1:ACC_W];
    sum   = {1'b0, acc_q} + {1'b0, step[ACC_W-1:0]};
    ce_d  = clr ? fast : (fast | sat | sum[ACC_W]);
    acc_d = clr ? '0 : ((fast | sat) ? acc_q : sum[ACC_W-1:0]);
    inc_d = wr ? inc_in : inc_q;
    // speed only moves on a pulse edge (or while idle) so no period is ever cut short
    spd_d = (ce_d | ~|inc_q) ? speed_in : spd_q;
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      acc_q <= '0;
      inc_q <= '0;
      spd_q <= '0;
      ce_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      inc_q <= inc_d;
      spd_q <= spd_d;
      ce_q  <= ce_d;
    end
  end
  assign ce        = ce_q;
  assign speed_act = spd_q;
endmodule

// File: rtl/ce_gen_multi.sv
// ce_gen_multi: multi-channel fractional clock-enable generator with turbo and fast-load.
// Optional CE_GEN_SYNC_EN adds a sync input that phase-aligns all accumulators.
module ce_gen_multi
  import ce_gen_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ACC_W   = 24,
  parameter int SPEED_W = SPEED_W_DEF
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic                      cfg_wr,
  input  logic [CH_W-1:0]           cfg_ch,
  input  logic [ACC_W-1:0]          cfg_inc,
  input  logic [NUM_CH*SPEED_W-1:0] speed,
  input  logic [NUM_CH-1:0]         fast,
`ifdef CE_GEN_SYNC_EN
  input  logic                      sync,
`endif
  output logic [NUM_CH-1:0]         ce,
  output logic [NUM_CH*SPEED_W-1:0] speed_act
);
  logic clr;
`ifdef CE_GEN_SYNC_EN
  assign clr = sync;
`else
  assign clr = 1'b0;
`endif
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ce_gen_chan #(.ACC_W(ACC_W), .SPEED_W(SPEED_W)) u_chan (
      .clk_sys   (clk_sys),
      .reset_n   (reset_n),
      .wr        (cfg_wr && (cfg_ch == CH_W'(k))),
      .inc_in    (cfg_inc),
      .speed_in  (speed[k*SPEED_W +: SPEED_W]),
      .fast      (fast[k]),
      .clr       (clr),
      .ce        (ce[k]),
      .speed_act (speed_act[k*SPEED_W +: SPEED_W])
    );
  end
endmodule
